// File: rtl/input_conditioner.sv
// Push-button conditioner: synchronizes and debounces three buttons, issues one-hot
// commands with a captured byte position. Optional auto-repeat: INPUT_CONDITIONER_AUTOREPEAT_EN.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] btn_raw,
    input  logic [7:0] sw_raw,
    input  logic       ack,
    output logic [2:0] btn,
    output logic [7:0] bytePos,
    output logic       busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    logic [2:0]         btn_s1_q, btn_s2_q;
    logic [7:0]         sw_s1_q, sw_s2_q;
    logic [2:0][CW-1:0] cnt_q, cnt_d;
    logic [2:0]         level_q, level_d;
    logic [2:0]         level_prev_q;
    logic [2:0]         press_s;
    logic [2:0]         pick_s;
    state_t             state_q, state_d;
    logic [2:0]         btn_q, btn_d;
    logic [7:0]         pos_q, pos_d;
    logic               busy_q, busy_d;

`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);
    localparam logic [RW-1:0] RPT_ONE  = RW'(1);

    logic [2:0]    cmd_q, cmd_d;
    logic [RW-1:0] timer_q, timer_d;
    logic          held_s;
    logic          rep_fire_s;

    assign held_s     = ((level_q & cmd_q) != 3'b000);
    assign rep_fire_s = held_s && (timer_q == RPT_LAST);
`else
    // Repeat interval has no effect without auto-repeat; keep it referenced.
    if (REPEAT_CYCLES < 1) begin : g_no_repeat
    end
`endif

    // Two-flop synchronizers for every raw input bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            btn_s1_q <= 3'b000;
            btn_s2_q <= 3'b000;
            sw_s1_q  <= 8'h00;
            sw_s2_q  <= 8'h00;
        end else begin
            btn_s1_q <= btn_raw;
            btn_s2_q <= btn_s1_q;
            sw_s1_q  <= sw_raw;
            sw_s2_q  <= sw_s1_q;
        end
    end

    // Per-button debounce counters and accepted levels.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        for (int i = 0; i < 3; i++) begin
            if (btn_s2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                cnt_d[i]   = '0;
                level_d[i] = ~level_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    assign press_s = level_q & ~level_prev_q;

    // Priority pick of the highest-index new press.
    always_comb begin
        if (press_s[2]) begin
            pick_s = 3'b100;
        end else if (press_s[1]) begin
            pick_s = 3'b010;
        end else if (press_s[0]) begin
            pick_s = 3'b001;
        end else begin
            pick_s = 3'b000;
        end
    end

    // Command FSM next-state and output logic.
    always_comb begin
        state_d = state_q;
        btn_d   = btn_q;
        pos_d   = pos_q;
        case (state_q)
            IDLE: begin
                if (press_s != 3'b000) begin
                    state_d = HOLD;
                    btn_d   = pick_s;
                    pos_d   = sw_s2_q;
                end else begin
                    btn_d = 3'b000;
                end
            end
            HOLD: begin
                if (ack) begin
                    state_d = RELEASE;
                    btn_d   = 3'b000;
                end else begin
                    btn_d = btn_q;
                end
            end
            RELEASE: begin
                btn_d = 3'b000;
                if (level_q == 3'b000) begin
                    state_d = IDLE;
`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
                end else if (rep_fire_s) begin
                    state_d = HOLD;
                    btn_d   = cmd_q;
                    pos_d   = sw_s2_q;
`endif
                end else begin
                    state_d = RELEASE;
                end
            end
            default: begin
                state_d = IDLE;
                btn_d   = 3'b000;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
    // Repeat timer runs from command issue while its button stays pressed.
    always_comb begin
        cmd_d = cmd_q;
        if (state_q == IDLE && state_d == HOLD) begin
            cmd_d = pick_s;
        end else begin
            cmd_d = cmd_q;
        end
        if (state_d == HOLD && state_q != HOLD) begin
            timer_d = '0;
        end else if (state_q != IDLE && held_s && timer_q != RPT_LAST) begin
            timer_d = timer_q + RPT_ONE;
        end else if (state_q != IDLE && held_s) begin
            timer_d = timer_q;
        end else begin
            timer_d = '0;
        end
    end

    // Repeat state registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cmd_q   <= 3'b000;
            timer_q <= '0;
        end else begin
            cmd_q   <= cmd_d;
            timer_q <= timer_d;
        end
    end
`endif

    // Debouncer and FSM registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q        <= '0;
            level_q      <= 3'b000;
            level_prev_q <= 3'b000;
            state_q      <= IDLE;
            btn_q        <= 3'b000;
            pos_q        <= 8'h00;
            busy_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            state_q      <= state_d;
            btn_q        <= btn_d;
            pos_q        <= pos_d;
            busy_q       <= busy_d;
        end
    end

    assign btn     = btn_q;
    assign bytePos = pos_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=20.
// A clean press shows on btn 7 ticks after btn_raw changes (2 sync + 4 debounce + 1).
module tb_input_conditioner;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] btn_raw = 3'b000;
    logic [7:0] sw_raw = 8'h00;
    logic       ack = 1'b0;
    logic [2:0] btn;
    logic [7:0] bytePos;
    logic       busy;

    int checks = 0;
    int errors = 0;

    input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_CYCLES(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_raw(btn_raw),
        .sw_raw(sw_raw),
        .ack(ack),
        .btn(btn),
        .bytePos(bytePos),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        btn_raw = 3'b111;
        sw_raw = 8'hff;
        tick(2);
        checks++; if (btn !== 3'b000) begin errors++; $display("FAIL reset_btn: got %b expected 000", btn); end
        checks++; if (bytePos !== 8'h00) begin errors++; $display("FAIL reset_pos: got %h expected 00", bytePos); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        btn_raw = 3'b000;
        tick(1);
        rst = 1'b1;
        tick(10);
        checks++; if (btn !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL reset_quiet: btn=%b busy=%b expected 000/0", btn, busy); end
    endtask

    task automatic test_press();
        int n;
        logic seen;
        sw_raw = 8'd50;
        btn_raw = 3'b100;
        tick(6);
        checks++; if (btn !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL press_early: btn=%b busy=%b expected 000/0", btn, busy); end
        tick(1);
        checks++; if (btn !== 3'b100) begin errors++; $display("FAIL press_btn: got %b expected 100", btn); end
        checks++; if (bytePos !== 8'd50) begin errors++; $display("FAIL press_pos: got %0d expected 50", bytePos); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL press_busy: got %b expected 1", busy); end
        sw_raw = 8'h77;
        tick(4);
        checks++; if (btn !== 3'b100 || bytePos !== 8'd50) begin errors++; $display("FAIL hold_stable: btn=%b pos=%0d expected 100/50", btn, bytePos); end
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        checks++; if (btn !== 3'b000 || busy !== 1'b1) begin errors++; $display("FAIL ack_release: btn=%b busy=%b expected 000/1", btn, busy); end
        // ack in RELEASE is ignored; no repeat in the default build.
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            ack = (i == 3) ? 1'b1 : 1'b0;
            tick(1);
`ifndef INPUT_CONDITIONER_AUTOREPEAT_EN
            if (btn !== 3'b000 || busy !== 1'b1) seen = 1'b1;
`else
            if (busy !== 1'b1) seen = 1'b1;
`endif
        end
        ack = 1'b0;
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL release_hold: got change=%b expected 0", seen); end
        btn_raw = 3'b000;
        n = 0;
        while (busy === 1'b1 && n < 40) begin tick(1); n++; end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL release_idle: busy=%b expected 0", busy); end
        checks++; if (bytePos !== 8'd50) begin errors++; $display("FAIL idle_pos: got %0d expected 50", bytePos); end
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        tick(2);
        checks++; if (btn !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL idle_ack: btn=%b busy=%b expected 000/0", btn, busy); end
    endtask

    task automatic test_glitch();
        logic seen;
        int n;
        seen = 1'b0;
        btn_raw = 3'b001;
        tick(2);
        btn_raw = 3'b000;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (btn !== 3'b000 || busy !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL glitch2: got event=%b expected 0", seen); end
        seen = 1'b0;
        btn_raw = 3'b001;
        tick(3);
        btn_raw = 3'b000;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (btn !== 3'b000 || busy !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL glitch3: got event=%b expected 0", seen); end
        btn_raw = 3'b001;
        tick(4);
        btn_raw = 3'b000;
        tick(3);
        checks++; if (btn !== 3'b001) begin errors++; $display("FAIL pulse4: got %b expected 001", btn); end
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin tick(1); n++; end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pulse4_idle: busy=%b expected 0", busy); end
    endtask

    task automatic test_priority();
        logic seen;
        int n;
        sw_raw = 8'h3c;
        btn_raw = 3'b011;
        tick(7);
        checks++; if (btn !== 3'b010 || bytePos !== 8'h3c) begin errors++; $display("FAIL prio_pick: btn=%b pos=%h expected 010/3c", btn, bytePos); end
        btn_raw = 3'b111;
        tick(10);
        checks++; if (btn !== 3'b010) begin errors++; $display("FAIL prio_hold_press: got %b expected 010", btn); end
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        tick(5);
        checks++; if (btn !== 3'b000 || busy !== 1'b1) begin errors++; $display("FAIL prio_release: btn=%b busy=%b expected 000/1", btn, busy); end
        btn_raw = 3'b000;
        n = 0;
        while (busy === 1'b1 && n < 40) begin tick(1); n++; end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prio_idle: busy=%b expected 0", busy); end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (btn !== 3'b000) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL prio_no_queue: got cmd=%b expected 0", seen); end
    endtask

    task automatic test_reset_hold();
        int ncmd;
        int first;
        int n;
        logic [2:0] prev;
        sw_raw = 8'h5a;
        btn_raw = 3'b001;
        tick(7);
        checks++; if (btn !== 3'b001) begin errors++; $display("FAIL rhold_btn: got %b expected 001", btn); end
        rst = 1'b0;
        ack = 1'b1;
        tick(1);
        rst = 1'b1;
        ack = 1'b0;
        checks++; if (btn !== 3'b000 || busy !== 1'b0 || bytePos !== 8'h00) begin errors++; $display("FAIL rhold_reset: btn=%b busy=%b pos=%h expected 000/0/00", btn, busy, bytePos); end
        ncmd = 0;
        first = -1;
        prev = 3'b000;
        for (int t = 1; t <= 20; t++) begin
            tick(1);
            if (btn !== 3'b000 && prev === 3'b000) begin
                ncmd++;
                if (first < 0) first = t;
            end
            prev = btn;
        end
        checks++; if (ncmd != 1) begin errors++; $display("FAIL rhold_count: got %0d expected 1", ncmd); end
        checks++; if (first != 7) begin errors++; $display("FAIL rhold_latency: got %0d expected 7", first); end
        checks++; if (btn !== 3'b001 || bytePos !== 8'h5a) begin errors++; $display("FAIL rhold_cmd: btn=%b pos=%h expected 001/5a", btn, bytePos); end
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        btn_raw = 3'b000;
        n = 0;
        while (busy === 1'b1 && n < 40) begin tick(1); n++; end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rhold_idle: busy=%b expected 0", busy); end
    endtask

    task automatic test_autorepeat();
        int ncmd;
        int t1;
        int t2;
        int n;
        logic [2:0] prev;
        ncmd = 0;
        t1 = -1;
        t2 = -1;
        prev = 3'b000;
        btn_raw = 3'b001;
        for (int t = 1; t <= 60; t++) begin
            tick(1);
            ack = 1'b0;
            if (btn === 3'b001 && prev === 3'b000) begin
                ncmd++;
                if (ncmd == 1) t1 = t;
                if (ncmd == 2) t2 = t;
                ack = 1'b1;
            end
            prev = btn;
        end
        ack = 1'b0;
        checks++; if (t1 != 7) begin errors++; $display("FAIL repeat_first: got %0d expected 7", t1); end
`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
        checks++; if (ncmd != 3) begin errors++; $display("FAIL repeat_count: got %0d expected 3", ncmd); end
        checks++; if (t2 - t1 != 20) begin errors++; $display("FAIL repeat_spacing: got %0d expected 20", t2 - t1); end
`else
        checks++; if (ncmd != 1) begin errors++; $display("FAIL repeat_count: got %0d expected 1", ncmd); end
`endif
        btn_raw = 3'b000;
        n = 0;
        while (busy === 1'b1 && n < 40) begin tick(1); n++; end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL repeat_idle: busy=%b expected 0", busy); end
    endtask

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_priority();
        test_reset_hold();
        test_autorepeat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, consecutive stable samples required to accept a raw level change.
REQ-002 Parameter REPEAT_CYCLES, default 25000000, hold time before auto-repeat (used only with INPUT_CONDITIONER_AUTOREPEAT_EN).
REQ-003 clk  input  1  single rising-edge system clock.
REQ-004 rst  input  1  synchronous, active-low reset; sampled on rising clk.
REQ-005 btn_raw  input  3  asynchronous push-button levels, 1 = pressed.
REQ-006 sw_raw  input  8  asynchronous slide-switch levels, byte position source.
REQ-007 ack  input  1  downstream processor has consumed the current command.
REQ-008 btn  output  3  one-hot command to processor; all-zero = no command.
REQ-009 bytePos  output  8  byte position captured with the current command.
REQ-010 busy  output  1  high while a command is held or its button is not yet released.

Function
REQ-011 Each btn_raw and sw_raw bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Each synchronized btn bit SHALL have its own debouncer: counter of width ceil(log2(DEBOUNCE_CYCLES+1)); counter clears when sample equals debounced level; debounced level toggles when counter reaches DEBOUNCE_CYCLES-1, counter then clears.
REQ-013 Press event = rising edge of a debounced level; a raw glitch shorter than DEBOUNCE_CYCLES SHALL produce no event.
REQ-014 FSM states: IDLE, HOLD, RELEASE.
REQ-015 IDLE: btn=0, busy=0; on any press event -> HOLD, btn loads one-hot of highest-index pressed bit (priority 2>1>0), bytePos loads synchronized sw_raw the same cycle.
REQ-016 HOLD: btn and bytePos SHALL stay constant; busy=1; on ack=1 -> RELEASE and btn=0 on the next cycle.
REQ-017 RELEASE: btn=0, busy=1; when all debounced levels are 0 -> IDLE.
REQ-018 Press events arriving in HOLD or RELEASE SHALL be discarded, not queued.
REQ-019 ack while in IDLE or RELEASE SHALL be ignored.
REQ-020 Latency: btn asserted exactly 2 (sync) + DEBOUNCE_CYCLES + 1 cycles after a clean btn_raw rise, ±1 for sampling phase.
REQ-021 bytePos SHALL hold its last captured value in IDLE and RELEASE; it changes only on the IDLE->HOLD transition.

Reset
REQ-022 With rst=0 at a rising clk: state=IDLE, btn=0, bytePos=0, busy=0, all synchronizers, debounced levels and counters=0.
REQ-023 Reset mid-HOLD SHALL drop btn to 0 on the next cycle; a button still held after reset SHALL be debounced afresh and issue one new command.
REQ-024 Reset SHALL take priority over ack and press events in the same cycle.

Configuration
REQ-025 Macro INPUT_CONDITIONER_AUTOREPEAT_EN defined: in RELEASE, if the command's button stays debounced-pressed for REPEAT_CYCLES cycles, FSM SHALL re-enter HOLD with the same btn and a freshly sampled bytePos, timer restarting on each repeat.
REQ-026 Macro undefined: no repeat timer logic compiled; RELEASE exits only on full release.

Verification (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=20)
REQ-027 rst=0 for 2 cycles with btn_raw=3'b111 -> btn=0, bytePos=0, busy=0.
REQ-028 sw_raw=50, btn_raw=3'b100 held 20 cycles, ack pulse at cycle 12 -> btn=3'b100, bytePos=50 from ~cycle 7 to ack+1, then btn=0, busy=1 until release.
REQ-029 btn_raw=3'b001 pulsed 2 cycles -> btn stays 0.
REQ-030 btn_raw=3'b011 simultaneous -> btn=3'b010 only; second press during HOLD -> ignored.
REQ-031 rst=0 during HOLD with btn_raw=1 still held -> btn=0 next cycle, then after release of rst exactly one new btn=3'b001 command.
REQ-032 AUTOREPEAT_EN defined, btn_raw=3'b001 held 60 cycles, ack 1 cycle after each btn -> repeated btn=3'b001 commands spaced 20 cycles; undefined -> exactly one command.
